// File: rtl/fifo_burst_reader.sv
// Burst reader: pulls burst_len words from a FIFO into a 2-entry skid buffer.
// Optional even-parity output DPAR is built when RDR_PARITY_EN is defined.
module fifo_burst_reader #(
  parameter int data_width = 9,
  parameter int burst_len  = 16
) (
  input  logic                  R_CLK,
  input  logic                  RRST,
  input  logic                  START,
  input  logic                  EMPTY,
  input  logic [data_width-1:0] O_DATA,
  output logic                  R_EN,
  output logic [data_width-1:0] DOUT,
  output logic                  DVALID,
  input  logic                  DREADY,
  output logic                  BUSY,
`ifdef RDR_PARITY_EN
  output logic                  DONE,
  output logic                  DPAR
`else
  output logic                  DONE
`endif
);

  localparam int CW = $clog2(burst_len + 1);
  localparam logic [CW-1:0] BL = CW'(burst_len);
  localparam logic [CW-1:0] BLM1 = CW'(burst_len - 1);

  typedef enum logic [1:0] {
    IDLE, READ, FLUSH, FINISH
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] xfr_q, xfr_d;
  logic pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;
  logic [data_width-1:0] buf0_q, buf0_d;
  logic [data_width-1:0] buf1_q, buf1_d;
  logic dvalid_q, dvalid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pop;
  logic [1:0] left;
`ifdef RDR_PARITY_EN
  logic dpar_q, dpar_d;
`endif

  always_comb begin
    pop = dvalid_q && DREADY;
    // Occupancy after this edge; lets a pop free a slot in the same cycle.
    left = cnt_q - 2'(pop) + 2'(pend_q);
    R_EN = (state_q == READ) && !EMPTY && (left < 2'd2) && (iss_q < BL);

    state_d = state_q;
    iss_d   = iss_q;
    xfr_d   = xfr_q;
    pend_d  = R_EN;
    cnt_d   = cnt_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;

    case (cnt_q)
      2'd0: begin
        if (pend_q) begin
          buf0_d = O_DATA;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && pend_q) begin
          buf0_d = O_DATA;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (pend_q) begin
          buf1_d = O_DATA;
          cnt_d  = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (pend_q) buf1_d = O_DATA;
          else cnt_d = 2'd1;
        end
      end
    endcase

    if (R_EN) iss_d = iss_q + 1'b1;
    if (pop && xfr_q < BL) xfr_d = xfr_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = READ;
          iss_d   = '0;
          xfr_d   = '0;
        end
      end
      READ: begin
        if (iss_q == BL) state_d = FLUSH;
      end
      FLUSH: begin
        if (pop && xfr_q == BLM1) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
    endcase

    dvalid_d = (cnt_d != 2'd0);
    busy_d   = (state_d == READ) || (state_d == FLUSH);
    done_d   = (state_d == FINISH);
`ifdef RDR_PARITY_EN
    dpar_d   = ^buf0_d;
`endif
  end

  always_ff @(posedge R_CLK or posedge RRST) begin
    if (RRST) begin
      state_q  <= IDLE;
      iss_q    <= '0;
      xfr_q    <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RDR_PARITY_EN
      dpar_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      xfr_q    <= xfr_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef RDR_PARITY_EN
      dpar_q   <= dpar_d;
`endif
    end
  end

  assign DOUT   = buf0_q;
  assign DVALID = dvalid_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
`ifdef RDR_PARITY_EN
  assign DPAR   = dpar_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO model.
// A second instance exercises burst_len = 1.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic RRST = 1'b1;
  logic START = 1'b0;
  logic DREADY = 1'b1;
  logic hold = 1'b0;
  logic EMPTY;
  logic [8:0] o_data = '0;
  logic R_EN, DVALID, BUSY, DONE;
  logic [8:0] DOUT;
  logic start1 = 1'b0;
  logic r_en1, dvalid1, busy1, done1;
  logic [8:0] dout1;
`ifdef RDR_PARITY_EN
  logic DPAR, dpar1;
`endif

  logic [8:0] mem [0:255];
  int wptr = 0;
  int rptr = 0;

  int n_tests = 0;
  int n_fail = 0;

  int ren_cnt, ren_first, ren_last;
  int xf_cnt, xf_first, xf_last;
  int busy_cnt, done_cnt, done_cyc;
  logic [8:0] xf_data [0:63];
  int ren1, xf1, done1_cnt, done1_cyc;
  logic [8:0] d1;

  always #5 clk = ~clk;

  assign EMPTY = (rptr == wptr) || hold;

  always @(posedge clk) begin
    if (RRST) rptr <= wptr;
    else if (R_EN) begin
      o_data <= mem[rptr % 256];
      rptr <= rptr + 1;
    end
  end

  fifo_burst_reader dut (
    .R_CLK(clk), .RRST(RRST), .START(START), .EMPTY(EMPTY),
    .O_DATA(o_data), .R_EN(R_EN), .DOUT(DOUT), .DVALID(DVALID),
    .DREADY(DREADY), .BUSY(BUSY),
`ifdef RDR_PARITY_EN
    .DPAR(DPAR),
`endif
    .DONE(DONE)
  );

  fifo_burst_reader #(.data_width(9), .burst_len(1)) u1 (
    .R_CLK(clk), .RRST(RRST), .START(start1), .EMPTY(1'b0),
    .O_DATA(9'h0A5), .R_EN(r_en1), .DOUT(dout1), .DVALID(dvalid1),
    .DREADY(1'b1), .BUSY(busy1),
`ifdef RDR_PARITY_EN
    .DPAR(dpar1),
`endif
    .DONE(done1)
  );

  task automatic fill(input int n, input logic [8:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wptr % 256] = base + 9'(i);
      wptr++;
    end
  endtask

  task automatic clear_log();
    ren_cnt = 0; ren_first = -1; ren_last = -1;
    xf_cnt = 0; xf_first = -1; xf_last = -1;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    ren1 = 0; xf1 = 0; done1_cnt = 0; done1_cyc = -1; d1 = '0;
  endtask

  task automatic sample(input int c);
    if (R_EN) begin
      ren_cnt++;
      if (ren_first < 0) ren_first = c;
      ren_last = c;
    end
    if (DVALID && DREADY && !RRST) begin
      if (xf_cnt < 64) xf_data[xf_cnt] = DOUT;
      xf_cnt++;
      if (xf_first < 0) xf_first = c;
      xf_last = c;
    end
    if (BUSY) busy_cnt++;
    if (DONE) begin done_cnt++; done_cyc = c; end
    if (r_en1) ren1++;
    if (dvalid1) begin xf1++; d1 = dout1; end
    if (done1) begin done1_cnt++; done1_cyc = c; end
  endtask

  task automatic cyc(input logic st, input logic rdy, input logic hd, input int c);
    @(negedge clk);
    START = st; DREADY = rdy; hold = hd;
    #1;
    sample(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RRST = 1'b1; START = 1'b0; DREADY = 1'b1; hold = 1'b0; start1 = 1'b0;
    #1;
    @(negedge clk);
    RRST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    RRST = 1'b1;
    #1;
    n_tests++;
    if ({R_EN, DVALID, BUSY, DONE} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 0000", {R_EN, DVALID, BUSY, DONE});
    end
    n_tests++;
    if (DOUT !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_dout got %h exp 000", DOUT);
    end
    @(negedge clk);
    RRST = 1'b0;
  endtask

  task automatic test_burst();
    do_reset();
    clear_log();
    fill(16, 9'h000);
    for (int c = 0; c < 26; c++) cyc(c == 0, 1'b1, 1'b0, c);
    n_tests++;
    if (ren_cnt != 16 || ren_first != 1 || ren_last != 16) begin
      n_fail++;
      $display("FAIL burst_ren got n=%0d %0d..%0d exp n=16 1..16", ren_cnt, ren_first, ren_last);
    end
    n_tests++;
    if (xf_cnt != 16 || xf_first != 3 || xf_last != 18) begin
      n_fail++;
      $display("FAIL burst_xfer got n=%0d %0d..%0d exp n=16 3..18", xf_cnt, xf_first, xf_last);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (xf_data[i] !== 9'(i)) begin
        n_fail++;
        $display("FAIL burst_word%0d got %h exp %h", i, xf_data[i], 9'(i));
      end
    end
    n_tests++;
    if (done_cnt != 1 || done_cyc != 19) begin
      n_fail++;
      $display("FAIL burst_done got n=%0d at %0d exp n=1 at 19", done_cnt, done_cyc);
    end
    n_tests++;
    if (busy_cnt != 18) begin
      n_fail++;
      $display("FAIL burst_busy got %0d exp 18", busy_cnt);
    end
  endtask

  task automatic test_stall();
    int ren_before, held_bad;
    do_reset();
    clear_log();
    fill(16, 9'h000);
    held_bad = 0;
    ren_before = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(c == 0, !(c >= 3 && c <= 7), 1'b0, c);
      if (c == 2) ren_before = ren_cnt;
      if (c >= 3 && c <= 7 && (DOUT !== 9'h000 || DVALID !== 1'b1)) held_bad++;
      if (c == 7) begin
        n_tests++;
        if (ren_cnt != 2 || ren_cnt != ren_before) begin
          n_fail++;
          $display("FAIL stall_ren got %0d exp 2", ren_cnt);
        end
      end
    end
    n_tests++;
    if (held_bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold got %0d bad cycles exp 0", held_bad);
    end
    n_tests++;
    if (xf_cnt != 16 || xf_first != 8 || xf_last != 23) begin
      n_fail++;
      $display("FAIL stall_xfer got n=%0d %0d..%0d exp n=16 8..23", xf_cnt, xf_first, xf_last);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (xf_data[i] !== 9'(i)) begin
        n_fail++;
        $display("FAIL stall_word%0d got %h exp %h", i, xf_data[i], 9'(i));
      end
    end
    n_tests++;
    if (done_cyc != 24 || ren_cnt != 16) begin
      n_fail++;
      $display("FAIL stall_done got %0d ren %0d exp 24 ren 16", done_cyc, ren_cnt);
    end
  endtask

  task automatic test_empty();
    int ren_gap, busy_gap;
    do_reset();
    clear_log();
    fill(16, 9'h020);
    ren_gap = 0;
    busy_gap = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(c == 0, 1'b1, (c >= 5 && c <= 8), c);
      if (c >= 5 && c <= 8) begin
        if (R_EN) ren_gap++;
        if (!BUSY) busy_gap++;
      end
    end
    n_tests++;
    if (ren_gap != 0 || busy_gap != 0) begin
      n_fail++;
      $display("FAIL empty_gap got ren=%0d busy_low=%0d exp 0 0", ren_gap, busy_gap);
    end
    n_tests++;
    if (ren_cnt != 16 || xf_cnt != 16 || xf_last != 22) begin
      n_fail++;
      $display("FAIL empty_counts got ren=%0d xf=%0d last=%0d exp 16 16 22", ren_cnt, xf_cnt, xf_last);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (xf_data[i] !== 9'h020 + 9'(i)) begin
        n_fail++;
        $display("FAIL empty_word%0d got %h exp %h", i, xf_data[i], 9'h020 + 9'(i));
      end
    end
    n_tests++;
    if (done_cyc != 23) begin
      n_fail++;
      $display("FAIL empty_done got %0d exp 23", done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    fill(16, 9'h040);
    for (int c = 0; c < 11; c++) cyc(c == 0, 1'b1, 1'b0, c);
    n_tests++;
    if (xf_cnt != 8 || xf_data[7] !== 9'h047) begin
      n_fail++;
      $display("FAIL rstmid_pre got n=%0d w7=%h exp 8 047", xf_cnt, xf_data[7]);
    end
    @(negedge clk);
    RRST = 1'b1;
    #1;
    n_tests++;
    if ({R_EN, DVALID, BUSY, DONE, DOUT} !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_out got %h exp 0", {R_EN, DVALID, BUSY, DONE, DOUT});
    end
    @(negedge clk);
    RRST = 1'b0;
    START = 1'b1;
    clear_log();
    fill(16, 9'h100);
    #1;
    sample(0);
    for (int c = 1; c < 26; c++) cyc(1'b0, 1'b1, 1'b0, c);
    n_tests++;
    if (xf_cnt != 16 || xf_first != 3 || done_cyc != 19) begin
      n_fail++;
      $display("FAIL rstmid_burst got n=%0d first=%0d done=%0d exp 16 3 19", xf_cnt, xf_first, done_cyc);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (xf_data[i] !== 9'h100 + 9'(i)) begin
        n_fail++;
        $display("FAIL rstmid_word%0d got %h exp %h", i, xf_data[i], 9'h100 + 9'(i));
      end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    clear_log();
    fill(20, 9'h080);
    for (int c = 0; c < 30; c++) cyc(c == 0 || c == 5 || c == 19, 1'b1, 1'b0, c);
    n_tests++;
    if (ren_cnt != 16 || xf_cnt != 16) begin
      n_fail++;
      $display("FAIL ignore_counts got ren=%0d xf=%0d exp 16 16", ren_cnt, xf_cnt);
    end
    n_tests++;
    if (done_cnt != 1 || busy_cnt != 18) begin
      n_fail++;
      $display("FAIL ignore_fsm got done=%0d busy=%0d exp 1 18", done_cnt, busy_cnt);
    end
    n_tests++;
    if (xf_data[15] !== 9'h08F) begin
      n_fail++;
      $display("FAIL ignore_last got %h exp 08f", xf_data[15]);
    end
  endtask

  task automatic test_len1();
    do_reset();
    clear_log();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      #1;
      sample(c);
    end
    n_tests++;
    if (ren1 != 1 || xf1 != 1 || d1 !== 9'h0A5) begin
      n_fail++;
      $display("FAIL len1_xfer got ren=%0d xf=%0d d=%h exp 1 1 0a5", ren1, xf1, d1);
    end
    n_tests++;
    if (done1_cnt != 1 || done1_cyc != 4) begin
      n_fail++;
      $display("FAIL len1_done got n=%0d at %0d exp 1 at 4", done1_cnt, done1_cyc);
    end
  endtask

`ifdef RDR_PARITY_EN
  task automatic test_parity();
    int seen;
    do_reset();
    clear_log();
    fill(1, 9'h1FF);
    fill(1, 9'h003);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(c == 0, 1'b1, 1'b0, c);
      if (DVALID && DOUT === 9'h1FF) begin
        seen++;
        n_tests++;
        if (DPAR !== 1'b1) begin
          n_fail++;
          $display("FAIL par_1ff got %b exp 1", DPAR);
        end
      end
      if (DVALID && DOUT === 9'h003) begin
        seen++;
        n_tests++;
        if (DPAR !== 1'b0) begin
          n_fail++;
          $display("FAIL par_003 got %b exp 0", DPAR);
        end
      end
    end
    n_tests++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL par_seen got %0d exp 2", seen);
    end
    do_reset();
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    RRST = 1'b0;
    test_reset();
    test_burst();
    test_stall();
    test_empty();
    test_reset_mid();
    test_start_ignored();
    test_len1();
`ifdef RDR_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter data_width, default 9, width of FIFO read data and DOUT.
REQ-002 SHALL have parameter burst_len, default 16, words read per burst (legal 1..1023).
REQ-003 SHALL have R_CLK  input  1  read-domain clock; the only clock; all state on its rising edge.
REQ-004 SHALL have RRST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have START  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have EMPTY  input  1  FIFO read-side empty flag.
REQ-007 SHALL have O_DATA  input  data_width  FIFO read data, valid the cycle after R_EN was sampled high.
REQ-008 SHALL have R_EN  output  1  FIFO read strobe.
REQ-009 SHALL have DOUT  output  data_width  downstream data.
REQ-010 SHALL have DVALID  output  1  DOUT holds a word.
REQ-011 SHALL have DREADY  input  1  downstream accepts; transfer when DVALID and DREADY both high at an edge.
REQ-012 SHALL have BUSY  output  1  burst in progress.
REQ-013 SHALL have DONE  output  1  one-cycle pulse after the last burst word transfers.
REQ-014 SHALL have DPAR  output  1  even parity of DOUT (only with RDR_PARITY_EN).

Function
REQ-015 SHALL implement FSM IDLE, READ, FLUSH, FINISH; IDLE->READ on START; READ->FLUSH when issued count reaches burst_len; FLUSH->FINISH when the last word transfers downstream; FINISH->IDLE unconditionally.
REQ-016 SHALL ignore START outside IDLE, including START in the FINISH cycle.
REQ-017 SHALL drive R_EN combinationally = state READ and !EMPTY and (buffered + in-flight words) < 2 and issued < burst_len.
REQ-018 SHALL never assert R_EN while EMPTY is high.
REQ-019 SHALL capture O_DATA one edge after each R_EN edge into a 2-entry output buffer; no word dropped or duplicated.
REQ-020 SHALL hold DOUT and DVALID stable while DVALID high and DREADY low.
REQ-021 SHALL, with buffer empty, EMPTY low, DREADY high: R_EN in cycle N, DVALID high in cycle N+2, first-word latency 2 cycles.
REQ-022 SHALL sustain one word per cycle in steady state (EMPTY low, DREADY high).
REQ-023 SHALL deliver words in FIFO order.
REQ-024 SHALL count issued reads and transferred words modulo nothing: counters saturate at burst_len, width clog2(burst_len+1).
REQ-025 SHALL keep BUSY high in READ and FLUSH, low in IDLE and FINISH; DONE high only in FINISH.
REQ-026 SHALL tolerate EMPTY asserting mid-burst: stall reads, keep BUSY, resume when EMPTY falls.
REQ-027 SHALL handle burst_len = 1: one R_EN, one transfer, DONE.

Reset
REQ-028 SHALL on RRST high immediately force IDLE, clear counters and buffer; R_EN 0, DVALID 0, BUSY 0, DONE 0, DOUT 0, DPAR 0.
REQ-029 SHALL on reset mid-burst discard in-flight and buffered words; no transfer on the release edge.
REQ-030 SHALL accept START on the first edge after RRST falls.

Configuration
REQ-031 SHALL with RDR_PARITY_EN defined drive DPAR = XOR of DOUT bits, registered with DOUT.
REQ-032 SHALL without RDR_PARITY_EN omit the DPAR port entirely; all other behaviour identical.

Verification
REQ-033 SHALL test: reset, FIFO holds 16 words 0x000..0x00F, START pulse, DREADY=1 -> 16 R_EN cycles back-to-back, DOUT 0x000..0x00F on consecutive cycles, DONE one cycle after last transfer.
REQ-034 SHALL test: DREADY=0 for 5 cycles after first DVALID -> at most 2 R_EN issued, DOUT held at 0x000, then resumes in order.
REQ-035 SHALL test: EMPTY high after word 3 for 4 cycles -> R_EN low during those cycles, BUSY high, words 4..15 follow without loss.
REQ-036 SHALL test: RRST pulse after word 7 -> all outputs 0 within the reset cycle, new START yields fresh 16-word burst.
REQ-037 SHALL test: START during READ and on DONE cycle -> ignored, exactly burst_len words transferred.
REQ-038 SHALL test with RDR_PARITY_EN: DOUT 0x1FF -> DPAR 1, DOUT 0x003 -> DPAR 0.
